// File: rtl/fix_point_div_pkg.sv
// Shared Q15.16 fixed-point definitions for the divider and multiplier.
package fix_point_pkg;

  localparam int unsigned FIX_WIDTH  = 32;
  localparam int unsigned FIX_FRAC_W = 16;

  localparam logic [FIX_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [FIX_WIDTH-1:0] Q_MIN = 32'h8000_0000;

  typedef logic [FIX_WIDTH-1:0] fix_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/fix_point_div_if.sv
// Operand/result handshake bundle for fix_point_div.
interface fix_point_div_if #(
  parameter int unsigned WIDTH = fix_point_pkg::FIX_WIDTH
);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             valid_o;
  logic [WIDTH-1:0] c_o;
  logic             ovf_o;
  logic             div0_o;

  modport slave (
    input  valid_i, a_i, b_i,
    output ready_o, valid_o, c_o, ovf_o, div0_o
  );

  modport master (
    output valid_i, a_i, b_i,
    input  ready_o, valid_o, c_o, ovf_o, div0_o
  );

endinterface

// File: rtl/fix_point_sign_mag.sv
// Conditional two's-complement negation: signed word -> magnitude when neg_i is the sign bit,
// magnitude -> signed word when neg_i is the result sign.
module fix_point_sign_mag #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? ((~x_i) + WIDTH'(1)) : x_i;

endmodule

// File: rtl/fix_point_div.sv
// Iterative signed Q-format divider, restoring shift-subtract, one quotient bit per clock.
// Define FIX_DIV_ROUND_EN for round-half-away-from-zero instead of truncation.
module fix_point_div
  import fix_point_pkg::*;
#(
  parameter int unsigned WIDTH  = FIX_WIDTH,
  parameter int unsigned FRAC_W = FIX_FRAC_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fix_point_div_if.slave bus
);

  localparam int unsigned ITER = WIDTH + FRAC_W;
  localparam int unsigned CntW = $clog2(ITER);

  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITER:0]    MagMaxPos = {{(FRAC_W+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ITER:0]    MagMaxNeg = MagMaxPos + {{ITER{1'b0}}, 1'b1};

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Holds the shifted dividend; quotient bits fill in from the LSB as dividend bits leave.
  logic [ITER-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             sign_q, sign_d;
  logic             aneg_q, aneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             ovf_q, ovf_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] mag_a, mag_b, q_res;
  logic [WIDTH:0]   trial, diff;
  logic             ge;
  logic             round_inc;
  logic [ITER:0]    q_fix;

  fix_point_sign_mag #(.WIDTH(WIDTH)) u_mag_a (
    .x_i   (bus.a_i),
    .neg_i (bus.a_i[WIDTH-1]),
    .y_o   (mag_a)
  );

  fix_point_sign_mag #(.WIDTH(WIDTH)) u_mag_b (
    .x_i   (bus.b_i),
    .neg_i (bus.b_i[WIDTH-1]),
    .y_o   (mag_b)
  );

  fix_point_sign_mag #(.WIDTH(WIDTH)) u_res (
    .x_i   (q_fix[WIDTH-1:0]),
    .neg_i (sign_q),
    .y_o   (q_res)
  );

  // Remainder stays below |b| <= 2^(WIDTH-1), so the shifted trial needs one extra bit.
  assign trial = {rem_q, dvd_q[ITER-1]};
  assign diff  = trial - {1'b0, bmag_q};
  assign ge    = (trial >= {1'b0, bmag_q});

`ifdef FIX_DIV_ROUND_EN
  assign round_inc = ({rem_q, 1'b0} >= {1'b0, bmag_q});
`else
  assign round_inc = 1'b0;
`endif

  assign q_fix = {1'b0, dvd_q} + {{ITER{1'b0}}, round_inc};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    bmag_d  = bmag_q;
    sign_d  = sign_q;
    aneg_d  = aneg_q;
    dz_d    = dz_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;

    unique case (state_q)
      StIdle: begin
        if (bus.valid_i) begin
          sign_d  = bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1];
          aneg_d  = bus.a_i[WIDTH-1];
          bmag_d  = mag_b;
          dvd_d   = {mag_a, {FRAC_W{1'b0}}};
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (bus.b_i == '0);
          state_d = dz_d ? StFix : StCalc;
        end
      end
      StCalc: begin
        rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[ITER-2:0], ge};
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFix: begin
        div0_d = 1'b0;
        if (dz_q) begin
          c_d    = aneg_q ? SatMin : SatMax;
          ovf_d  = 1'b1;
          div0_d = 1'b1;
        end else if (!sign_q && (q_fix > MagMaxPos)) begin
          c_d   = SatMax;
          ovf_d = 1'b1;
        end else if (sign_q && (q_fix > MagMaxNeg)) begin
          c_d   = SatMin;
          ovf_d = 1'b1;
        end else begin
          c_d   = q_res;
          ovf_d = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      bmag_q  <= '0;
      sign_q  <= 1'b0;
      aneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      bmag_q  <= bmag_d;
      sign_q  <= sign_d;
      aneg_q  <= aneg_d;
      dz_q    <= dz_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.ready_o = (state_q == StIdle);
  assign bus.valid_o = (state_q == StDone);
  assign bus.c_o     = c_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.div0_o  = div0_q;

endmodule

// File: tb/tb_fix_point_div.sv
// Scoreboard bench for fix_point_div: directed cases, reset abort, busy-ignore and random ops.
module tb_fix_point_div;
  import fix_point_pkg::*;

  localparam int unsigned W = FIX_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fix_point_div_if #(.WIDTH(W)) bus ();

  fix_point_div #(.WIDTH(W), .FRAC_W(FIX_FRAC_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic        ovf;
    logic        div0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   edges = 0;
  int   acc_stamp = 0;
  bit   ready_next = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] c, input logic ovf, input logic div0,
                              input int lat);
    exp_t e;
    e.c = c; e.ovf = ovf; e.div0 = div0; e.lat = lat;
    return e;
  endfunction

  // Reference: exact integer division of magnitudes, then sign and saturation.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sbv, n, d, q, r, s;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (b == 32'd0) return mk((sa >= 0) ? Q_MAX : Q_MIN, 1'b1, 1'b1, 2);
    n = ((sa < 0) ? -sa : sa) * 65536;
    d = (sbv < 0) ? -sbv : sbv;
    q = n / d;
    r = n % d;
`ifdef FIX_DIV_ROUND_EN
    if (2 * r >= d) q = q + 1;
`else
    if (r < 0) q = 0;
`endif
    s = ((sa < 0) != (sbv < 0)) ? -q : q;
    if (s > 64'sd2147483647)       e = mk(Q_MAX, 1'b1, 1'b0, 50);
    else if (s < -64'sd2147483648) e = mk(Q_MIN, 1'b1, 1'b0, 50);
    else                           e = mk(s[31:0], 1'b0, 1'b0, 50);
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      edges++;
      if (rst) begin
        ready_next = 1'b0;
      end else begin
        if (ready_next) begin
          chk("ready_after_done", {63'd0, bus.ready_o}, 64'd1);
          ready_next = 1'b0;
        end
        if (bus.valid_o) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: got c=0x%0h with no operation pending", bus.c_o);
          end else begin
            e = sb.pop_front();
            chk("c_o", {32'd0, bus.c_o}, {32'd0, e.c});
            chk("ovf_o", {63'd0, bus.ovf_o}, {63'd0, e.ovf});
            chk("div0_o", {63'd0, bus.div0_o}, {63'd0, e.div0});
            chk("latency", 64'(edges - acc_stamp), 64'(e.lat));
            chk("ready_in_done", {63'd0, bus.ready_o}, 64'd0);
            ready_next = 1'b1;
          end
        end
        if (bus.valid_i && bus.ready_o) acc_stamp = edges;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int t = 0;
    while (!bus.ready_o && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.ready_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: ready_o=0 after %0d cycles, expected 1", t);
      return;
    end
    bus.a_i     = a;
    bus.b_i     = b;
    bus.valid_i = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
  endtask

  task automatic chk_reset_vals();
    @(negedge clk);
    chk("rst_ready", {63'd0, bus.ready_o}, 64'd1);
    chk("rst_valid", {63'd0, bus.valid_o}, 64'd0);
    chk("rst_c", {32'd0, bus.c_o}, 64'd0);
    chk("rst_ovf", {63'd0, bus.ovf_o}, 64'd0);
    chk("rst_div0", {63'd0, bus.div0_o}, 64'd0);
  endtask

  initial begin : stim
    logic [31:0] a, b;
    int          t;
    bus.valid_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (2) @(posedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    issue(32'h0003_0000, 32'h0002_0000, mk(32'h0001_8000, 1'b0, 1'b0, 50));
    issue(32'hFFFE_8000, 32'h0000_8000, mk(32'hFFFD_0000, 1'b0, 1'b0, 50));
    issue(32'hFFFE_8000, 32'hFFFF_8000, mk(32'h0003_0000, 1'b0, 1'b0, 50));
`ifdef FIX_DIV_ROUND_EN
    issue(32'h0002_0000, 32'h0003_0000, mk(32'h0000_AAAB, 1'b0, 1'b0, 50));
    issue(32'hFFFE_0000, 32'h0003_0000, mk(32'hFFFF_5555, 1'b0, 1'b0, 50));
`else
    issue(32'h0002_0000, 32'h0003_0000, mk(32'h0000_AAAA, 1'b0, 1'b0, 50));
    issue(32'hFFFE_0000, 32'h0003_0000, mk(32'hFFFF_5556, 1'b0, 1'b0, 50));
`endif
    issue(32'h4000_0000, 32'h0000_0100, mk(32'h7FFF_FFFF, 1'b1, 1'b0, 50));
    issue(32'h8000_0000, 32'h0001_0000, mk(32'h8000_0000, 1'b0, 1'b0, 50));
    issue(32'hC000_0000, 32'h0000_0100, mk(32'h8000_0000, 1'b1, 1'b0, 50));
    issue(32'hFFFF_0000, 32'h0000_0000, mk(32'h8000_0000, 1'b1, 1'b1, 2));
    issue(32'h0000_0000, 32'hFFFF_0000, mk(32'h0000_0000, 1'b0, 1'b0, 50));

    // Abort an operation mid-flight; the scoreboard entry is dropped with it.
    issue(32'h0003_0000, 32'h0002_0000, mk(32'h0001_8000, 1'b0, 1'b0, 50));
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    chk_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    issue(32'h0001_0000, 32'h0004_0000, mk(32'h0000_4000, 1'b0, 1'b0, 50));
    for (int i = 0; i < 5; i++) begin
      repeat (3) @(posedge clk);
      #1;
      bus.valid_i = 1'b1;
      bus.a_i     = $urandom;
      bus.b_i     = $urandom;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
    end

    for (int i = 0; i < 30; i++) begin
      a = $urandom >> $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) a = -a;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 9) == 0) b = 32'd0;
      issue(a, b, model(a, b));
    end

    t = 0;
    while ((sb.size() != 0 || !bus.ready_o) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
